// File: rtl/apu_pkg.sv
// Shared constants and types for the APU frame sequencer and its per-channel length slots.
package apu_pkg;

    localparam int FRAME_STEPS  = 8;
    localparam int LEN_MAX_SQ   = 64;
    localparam int LEN_MAX_WAVE = 256;

    typedef enum logic [1:0] {
        CH_SQ1,
        CH_SQ2,
        CH_WAVE,
        CH_NOISE
    } ch_idx_e;

    // Bit n set means the tick fires when the sequencer enters step n.
    localparam logic [7:0] LEN_STEPS   = 8'b01010101;
    localparam logic [7:0] SWEEP_STEPS = 8'b01000100;
    localparam logic [7:0] ENV_STEPS   = 8'b10000000;

    function automatic logic step_hit(input logic [7:0] mask, input logic [2:0] step);
        return mask[step];
    endfunction

endpackage

// File: rtl/apu_len_slot.sv
// One channel's length counter plus its trigger/restart and channel-active status.
module apu_len_slot
    import apu_pkg::*;
#(
    parameter int MAX   = 64,
    parameter int VAL_W = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             master_en_i,
    input  logic             trig_i,
    input  logic             len_en_i,
    input  logic             len_load_i,
    input  logic [VAL_W-1:0] len_val_i,
    input  logic             dac_on_i,
    input  logic             clr_i,
    input  logic             length_tick_i,
    output logic             restart_o,
    output logic             active_o
);

    localparam logic [8:0] MAX_V = 9'(MAX);

    logic [8:0] cnt_q;
    logic [8:0] load_d;
    logic       active_q;
    logic       restart_q;
    logic       dac_q;
    logic       dec;
    logic       expire;

    assign load_d = MAX_V - 9'(len_val_i);
    // Load and trigger both take precedence over a decrement in the same cycle.
    assign dec    = !len_load_i && !trig_i && length_tick_i && len_en_i && (cnt_q != 9'd0);
    assign expire = dec && (cnt_q == 9'd1);

    always_ff @(posedge clk_i) begin
        if (reset_i || !master_en_i) begin
            cnt_q     <= '0;
            active_q  <= 1'b0;
            restart_q <= 1'b0;
            dac_q     <= 1'b0;
        end else begin
            dac_q     <= dac_on_i;
            restart_q <= trig_i && dac_on_i;

            if (len_load_i) begin
                cnt_q <= load_d;
            end else if (trig_i) begin
                if (cnt_q == 9'd0) begin
                    cnt_q <= MAX_V;
                end
            end else if (dec) begin
                cnt_q <= cnt_q - 9'd1;
            end

            if (trig_i) begin
                active_q <= dac_on_i;
            end else if ((dac_q && !dac_on_i) || clr_i || expire) begin
                active_q <= 1'b0;
            end
        end
    end

    assign restart_o = restart_q;
    assign active_o  = active_q;

endmodule

// File: rtl/apu_frame_sequencer.sv
// Frame-step prescaler and tick decoder for the APU, plus the four per-channel length slots.
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int CLK_DIV = 32768
) (
    input  logic       system_clock,
    input  logic       reset,
    input  logic       master_en,
    input  logic [3:0] trig,
    input  logic [3:0] len_en,
    input  logic [3:0] len_load,
    input  logic [7:0] len_val,
    input  logic [3:0] dac_on,
    input  logic       sweep_overflow,
    output logic [2:0] frame_step,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic [3:0] restart,
    output logic [3:0] ch_active
);

    localparam int PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int STEP_W = $clog2(FRAME_STEPS);

    logic [PW-1:0]     presc_q;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              len_tick_q;
    logic              sweep_tick_q;
    logic              env_tick_q;
    logic              wrap;

    assign wrap   = (presc_q == PW'(CLK_DIV - 1));
    assign step_d = step_q + STEP_W'(1);

    // Idle step is 7 so the first step after reset or enable is 0.
    always_ff @(posedge system_clock) begin
        if (reset || !master_en) begin
            presc_q      <= '0;
            step_q       <= '1;
            len_tick_q   <= 1'b0;
            sweep_tick_q <= 1'b0;
            env_tick_q   <= 1'b0;
        end else begin
            presc_q      <= wrap ? '0 : presc_q + PW'(1);
            len_tick_q   <= wrap && step_hit(LEN_STEPS, step_d);
            sweep_tick_q <= wrap && step_hit(SWEEP_STEPS, step_d);
            env_tick_q   <= wrap && step_hit(ENV_STEPS, step_d);
            if (wrap) begin
                step_q <= step_d;
            end
        end
    end

    assign frame_step  = step_q;
    assign length_tick = len_tick_q;
    assign sweep_tick  = sweep_tick_q;
    assign env_tick    = env_tick_q;

    for (genvar g = 0; g < 4; g++) begin : g_slot
        localparam int MAX = (g == int'(CH_WAVE)) ? LEN_MAX_WAVE : LEN_MAX_SQ;
        localparam int VW  = (g == int'(CH_WAVE)) ? 8 : 6;

        apu_len_slot #(
            .MAX   (MAX),
            .VAL_W (VW)
        ) u_slot (
            .clk_i         (system_clock),
            .reset_i       (reset),
            .master_en_i   (master_en),
            .trig_i        (trig[g]),
            .len_en_i      (len_en[g]),
            .len_load_i    (len_load[g]),
            .len_val_i     (len_val[VW-1:0]),
            .dac_on_i      (dac_on[g]),
            .clr_i         ((g == int'(CH_SQ1)) ? sweep_overflow : 1'b0),
            .length_tick_i (len_tick_q),
            .restart_o     (restart[g]),
            .active_o      (ch_active[g])
        );
    end

endmodule
